// File: rtl/alu_muldiv_unit.sv
// RV32M multiply/divide unit: decodes M-group ops and runs them on an iterative
// shift-add multiplier / restoring divider, stalling EX while busy.
module alu_muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            RType,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush_i,
  output logic            is_muldiv_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] Result_o
);

  localparam int unsigned STEPS = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0]   LAST    = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t          state;
  logic [2:0]      f3;
  logic            neg_lo, neg_hi;
  logic [XLEN-1:0] oper, hi, lo;
  logic [CW-1:0]   cnt;

  logic            accept, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, nhi, nlo, q_fix, r_fix, fin_res;
  logic [XLEN:0]   sum, rem;
  logic [2*XLEN-1:0] prod;

  assign is_muldiv_o = RType & (ALUOp == 2'b10) & (Funct7 == 7'b0000001);
  assign accept      = (state == IDLE) & valid_i & is_muldiv_o & ~flush_i;
  assign busy_o      = accept | (state == CALC) | (state == FIN);
  assign ready_o     = (state == IDLE);

  always_comb begin
    a_signed = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    b_signed = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
    a_neg    = a_signed & SrcA[XLEN-1];
    b_neg    = b_signed & SrcB[XLEN-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    div_zero = (SrcB == '0);
    div_ovf  = a_signed & (SrcA == MIN_NEG) & (SrcB == '1);
    fast     = Funct3[2] & (div_zero | div_ovf);
  end

  // Multiply: {hi,lo} shifts right with the multiplier consumed from lo[0].
  // Divide: lo holds the dividend shifting out MSB-first and collects quotient bits.
  always_comb begin
    nhi = hi;
    nlo = lo;
    sum = '0;
    rem = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!f3[2]) begin
        sum = {1'b0, nhi} + (nlo[0] ? {1'b0, oper} : '0);
        nlo = {sum[0], nlo[XLEN-1:1]};
        nhi = sum[XLEN:1];
      end else begin
        rem = {nhi, nlo[XLEN-1]};
        nlo = {nlo[XLEN-2:0], 1'b0};
        if (rem >= {1'b0, oper}) begin
          rem    = rem - {1'b0, oper};
          nlo[0] = 1'b1;
        end
        nhi = rem[XLEN-1:0];
      end
    end
  end

  always_comb begin
    prod    = neg_lo ? -{hi, lo} : {hi, lo};
    q_fix   = neg_lo ? -lo : lo;
    r_fix   = neg_hi ? -hi : hi;
    fin_res = '0;
    if (f3[2])                fin_res = f3[1] ? r_fix : q_fix;
    else if (f3[1:0] == 2'b00) fin_res = prod[XLEN-1:0];
    else                       fin_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      f3       <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      oper     <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      done_o   <= 1'b0;
      Result_o <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (accept) begin
            f3  <= Funct3;
            cnt <= '0;
            if (fast) begin
              // Special-case results preloaded as quotient (lo) / remainder (hi)
              state  <= FIN;
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
              oper   <= b_mag;
              lo     <= div_zero ? '1 : SrcA;
              hi     <= div_zero ? SrcA : '0;
            end else begin
              state  <= CALC;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
              oper   <= Funct3[2] ? b_mag : a_mag;
              lo     <= Funct3[2] ? a_mag : b_mag;
              hi     <= '0;
            end
          end
        end
        CALC: begin
          hi <= nhi;
          lo <= nlo;
          if (cnt == LAST) state <= FIN;
          else             cnt   <= cnt + CW'(1);
        end
        FIN: begin
          Result_o <= fin_res;
          done_o   <= 1'b1;
          state    <= DONE;
        end
        default: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: two instances (1 and 4 bits/cycle)
// checked against an arithmetic reference model, plus flush/reset/decode cases.
module tb_alu_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst1, rst4, valid1, valid4, flush1, flush4;
  logic        RType;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        ism1, rdy1, bsy1, dn1, ism4, rdy4, bsy4, dn4;
  logic [31:0] res1, res4;

  typedef struct { logic [31:0] res; int cyc; } exp_t;
  exp_t q1[$];
  exp_t q4[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] last1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(rst1), .valid_i(valid1), .RType(RType), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush_i(flush1),
    .is_muldiv_o(ism1), .ready_o(rdy1), .busy_o(bsy1), .done_o(dn1), .Result_o(res1));

  alu_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(rst4), .valid_i(valid4), .RType(RType), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush_i(flush4),
    .is_muldiv_o(ism4), .ready_o(rdy4), .busy_o(bsy4), .done_o(dn4), .Result_o(res4));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int si, sj;
    bit ovf;
    sa = {{32{a[31]}}, a};  sb = {{32{b[31]}}, b};
    ua = {32'b0, a};        ub = {32'b0, b};
    si = a;                 sj = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(si / sj);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % sj);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int bpc);
    bit is_div, is_signed;
    is_div    = (f3 >= 3'd4);
    is_signed = (f3 == 3'd4) || (f3 == 3'd6);
    if (is_div && (b == 0 || (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    return 32 / bpc + 2;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (dn1) begin
      if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_result", res1, e.res);
        check("dut1_done_cycle", cyc, e.cyc);
      end
    end
    if (dn4) begin
      if (q4.size() == 0) check("dut4_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        check("dut4_result", res4, e.res);
        check("dut4_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(rdy1 && rdy4)) begin
      step();
      n++;
      if (n > 200) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit en1, input bit en4, input bit push);
    exp_t e;
    RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001;
    Funct3 = f3; SrcA = a; SrcB = b;
    valid1 = en1; valid4 = en4;
    if (push && en1) begin
      e.res = model(f3, a, b); e.cyc = cyc + latency(f3, a, b, 1);
      q1.push_back(e); last1 = e.res;
    end
    if (push && en4) begin
      e.res = model(f3, a, b); e.cyc = cyc + latency(f3, a, b, 4);
      q4.push_back(e);
    end
    #1;
    if (en1) check("dut1_accept_busy", bsy1, 1);
    if (en4) check("dut4_accept_busy", bsy4, 1);
    step();
    valid1 = 1'b0; valid4 = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int acc;
    rst1 = 1'b0; rst4 = 1'b0; valid1 = 1'b0; valid4 = 1'b0; flush1 = 1'b0; flush4 = 1'b0;
    RType = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {rdy1, rdy4}, 2'b11);
    check("reset_busy", {bsy1, bsy4}, 2'b00);
    check("reset_done", {dn1, dn4}, 2'b00);
    check("reset_result", {res1, res4}, 64'h0);
    rst1 = 1'b1; rst4 = 1'b1;
    step();

    // MUL 7 * -3 with stall profile over the whole operation
    wait_ready();
    acc = cyc;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 1, 1);
    for (int k = 1; k <= 34; k++) begin
      check("mul_busy_profile", bsy1, (cyc - acc) < 34);
      if (k < 34) step();
    end

    wait_ready(); issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 1, 1);
    wait_ready(); issue(3'd3, 32'h8000_0000, 32'h8000_0000, 1, 1, 1);
    wait_ready(); issue(3'd2, 32'h8000_0000, 32'h8000_0000, 1, 1, 1);
    wait_ready(); issue(3'd4, 32'd5, 32'd0, 1, 1, 1);
    wait_ready(); issue(3'd7, 32'd5, 32'd0, 1, 1, 1);
    wait_ready(); issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1);
    wait_ready(); issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1);
    wait_ready(); issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 1, 1);
    wait_ready(); issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 1, 1);
    wait_ready(); issue(3'd5, 32'd100, 32'd7, 1, 1, 1);
    wait_ready(); issue(3'd7, 32'd100, 32'd7, 1, 1, 1);

    // Flush during cycle 10 of a MUL: aborted, result register untouched
    wait_ready();
    acc = cyc;
    issue(3'd0, 32'd5, 32'd9, 1, 0, 0);
    while (cyc < acc + 10) step();
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    check("flush_ready", rdy1, 1);
    check("flush_result_held", res1, last1);
    check("flush_no_done", dn1, 0);
    repeat (40) step();

    // Asynchronous reset in cycle 5 of a MUL
    wait_ready();
    acc = cyc;
    issue(3'd0, 32'd3, 32'd4, 1, 0, 0);
    while (cyc < acc + 5) step();
    rst1 = 1'b0;
    #1;
    check("midreset_ready", rdy1, 1);
    check("midreset_busy", bsy1, 0);
    check("midreset_result", res1, 0);
    check("midreset_done", dn1, 0);
    step();
    rst1 = 1'b1;
    last1 = '0;
    repeat (40) step();

    // Non-M encodings are not decoded and never accepted
    wait_ready();
    RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000000; valid1 = 1'b1; valid4 = 1'b1;
    #1;
    check("add_is_muldiv", {ism1, ism4}, 2'b00);
    check("add_busy", {bsy1, bsy4}, 2'b00);
    step();
    check("add_ready", {rdy1, rdy4}, 2'b11);
    RType = 1'b0; Funct7 = 7'b0000001;
    #1;
    check("itype_is_muldiv", {ism1, ism4}, 2'b00);
    check("itype_busy", {bsy1, bsy4}, 2'b00);
    step();
    check("itype_ready", {rdy1, rdy4}, 2'b11);

    // Qualifying request together with flush is dropped
    RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; flush1 = 1'b1; flush4 = 1'b1;
    #1;
    check("flushreq_is_muldiv", ism1, 1);
    check("flushreq_busy", {bsy1, bsy4}, 2'b00);
    step();
    valid1 = 1'b0; valid4 = 1'b0; flush1 = 1'b0; flush4 = 1'b0;
    check("flushreq_ready", {rdy1, rdy4}, 2'b11);
    repeat (5) step();

    // Randomised operations with corner-biased operands
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: begin a = -32'($urandom_range(1, 50)); b = $urandom_range(1, 9); end
        4: begin a = $urandom_range(0, 50); b = -32'($urandom_range(1, 9)); end
        default: ;
      endcase
      wait_ready();
      issue(f3, a, b, 1, 1, 1);
    end

    wait_ready();
    repeat (5) step();
    check("dut1_outstanding", q1.size(), 0);
    check("dut4_outstanding", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
